// File: rtl/dcache_control.sv
// Control FSM for a 2-way set-associative, write-back, LRU data cache: hit service,
// dirty-victim writeback and line fill, plus saturating hit/miss/writeback counters.
module dcache_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             hit0,
    input  logic             hit1,
    input  logic             lru_valid,
    input  logic             lru_dirty,
    input  logic             pmem_resp,
    input  logic             clr_stats,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             way_sel,
    output logic [1:0]       data_wdata_sel,
    output logic             data_wren_sel,
    output logic             resp_sel,
    output logic             ma_sel,
    output logic [1:0]       hit_sel,
    output logic             dirty_wren_sel,
    output logic             lru_wdata_sel,
    output logic             data_we,
    output logic             tag_we,
    output logic             valid_we,
    output logic             dirty_we,
    output logic             lru_we,
    output logic             dirty_wdata,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WB   = 2'b01,
        FILL = 2'b10
    } state_t;

    state_t state_reg, state_next;

    logic req, hit;
    logic [2:0] cnt_inc;              // {wb, miss, hit}
    logic [3*CNT_W-1:0] cnt_all;

    assign req = mem_read | mem_write;
    assign hit = hit0 | hit1;

    // Mealy decode: every select is a function of the current state and live inputs.
    always_comb begin
        state_next     = state_reg;
        cnt_inc        = 3'b000;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        way_sel        = 1'b0;
        data_wdata_sel = 2'b00;
        data_wren_sel  = 1'b0;
        resp_sel       = 1'b0;
        ma_sel         = 1'b0;
        hit_sel        = 2'b00;
        dirty_wren_sel = 1'b0;
        lru_wdata_sel  = 1'b0;
        data_we        = 1'b0;
        tag_we         = 1'b0;
        valid_we       = 1'b0;
        dirty_we       = 1'b0;
        lru_we         = 1'b0;
        dirty_wdata    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req && hit) begin
                    mem_resp      = 1'b1;
                    lru_we        = 1'b1;
                    lru_wdata_sel = 1'b1;
                    cnt_inc[0]    = 1'b1;
                    if (mem_write) begin
                        data_we       = 1'b1;
                        data_wren_sel = 1'b1;
                        dirty_we      = 1'b1;
                        dirty_wdata   = 1'b1;
                    end
                end else if (req) begin
                    hit_sel    = 2'b10;
                    cnt_inc[1] = 1'b1;
                    state_next = (lru_valid && lru_dirty) ? WB : FILL;
                end
            end
            WB: begin
                hit_sel    = 2'b10;
                way_sel    = 1'b1;
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    cnt_inc[2] = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                hit_sel   = 2'b10;
                ma_sel    = 1'b1;
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    // Install the line and answer the CPU in the same cycle.
                    data_we        = 1'b1;
                    tag_we         = 1'b1;
                    valid_we       = 1'b1;
                    dirty_we       = 1'b1;
                    dirty_wren_sel = 1'b1;
                    data_wdata_sel = mem_write ? 2'b10 : 2'b01;
                    dirty_wdata    = mem_write;
                    lru_we         = 1'b1;
                    hit_sel        = 2'b11;
                    mem_resp       = 1'b1;
                    resp_sel       = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // One saturating counter per event; clear beats a same-cycle increment.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst || clr_stats) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            assign cnt_all[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    assign hit_count  = cnt_all[0*CNT_W +: CNT_W];
    assign miss_count = cnt_all[1*CNT_W +: CNT_W];
    assign wb_count   = cnt_all[2*CNT_W +: CNT_W];

endmodule

// File: tb/tb_dcache_control.sv
// Scoreboard bench for dcache_control: a planned-transaction driver pushes expected
// responses, a negedge monitor pops and compares them when mem_resp appears.
module tb_dcache_control;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, mem_read, mem_write, hit0, hit1, lru_valid, lru_dirty, pmem_resp, clr_stats;
    logic mem_resp, pmem_read, pmem_write, way_sel, data_wren_sel, resp_sel, ma_sel;
    logic dirty_wren_sel, lru_wdata_sel, data_we, tag_we, valid_we, dirty_we, lru_we, dirty_wdata;
    logic [1:0] data_wdata_sel, hit_sel;
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;

    dcache_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .lru_valid(lru_valid), .lru_dirty(lru_dirty),
        .pmem_resp(pmem_resp), .clr_stats(clr_stats), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .way_sel(way_sel),
        .data_wdata_sel(data_wdata_sel), .data_wren_sel(data_wren_sel),
        .resp_sel(resp_sel), .ma_sel(ma_sel), .hit_sel(hit_sel),
        .dirty_wren_sel(dirty_wren_sel), .lru_wdata_sel(lru_wdata_sel),
        .data_we(data_we), .tag_we(tag_we), .valid_we(valid_we), .dirty_we(dirty_we),
        .lru_we(lru_we), .dirty_wdata(dirty_wdata), .hit_count(hit_count),
        .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          n_wr;
        int          n_rd;
        logic [17:0] resp;
        int          c_hit;
        int          c_miss;
        int          c_wb;
    } exp_t;

    exp_t sb_q[$];
    int vectors = 0;
    int miscompares = 0;
    int m_hit = 0, m_miss = 0, m_wb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] pack(input logic [1:0] hs, input logic ws,
        input logic [1:0] wds, input logic wrs, dwe, rs, tw, vw, dw, dws, dwd, lw, lws, pr, pw, ma);
        return {hs, ws, wds, wrs, dwe, rs, tw, vw, dw, dws, dwd, lw, lws, pr, pw, ma};
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    logic [17:0] out_vec;
    assign out_vec = {hit_sel, way_sel, data_wdata_sel, data_wren_sel, data_we, resp_sel,
                      tag_we, valid_we, dirty_we, dirty_wren_sel, dirty_wdata, lru_we,
                      lru_wdata_sel, pmem_read, pmem_write, ma_sel};

    // One CPU transaction; memory timing is planned up front, so the driver never waits on the DUT.
    task automatic do_txn(input logic wr, input logic rd, input logic [1:0] hits, input logic lv,
                          input logic ld, input int wb_lat, input int fill_lat, input logic clr,
                          input int gap);
        exp_t e;
        logic is_hit, dirty;
        is_hit = (hits != 2'b00);
        dirty  = !is_hit && lv && ld;
        e.n_wr = dirty ? wb_lat : 0;
        e.n_rd = is_hit ? 0 : fill_lat;
        e.lat  = is_hit ? 1 : 1 + e.n_wr + e.n_rd;
        if (is_hit) begin
            e.resp = pack(2'b00, 1'b0, 2'b00, wr, wr, 1'b0, 1'b0, 1'b0, wr, 1'b0, wr,
                          1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            m_hit = sat(m_hit + 1);
        end else begin
            e.resp = pack(2'b11, 1'b0, wr ? 2'b10 : 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                          1'b1, wr, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            m_miss = sat(m_miss + 1);
            if (dirty) m_wb = sat(m_wb + 1);
        end
        if (clr) begin
            m_hit = 0; m_miss = 0; m_wb = 0;
        end
        e.c_hit = m_hit; e.c_miss = m_miss; e.c_wb = m_wb;
        sb_q.push_back(e);
        for (int c = 0; c < e.lat; c++) begin
            mem_write = wr;
            mem_read  = rd;
            if (c == 0) begin
                hit0 = hits[0]; hit1 = hits[1];
                lru_valid = lv; lru_dirty = ld;
                pmem_resp = 1'($urandom_range(0, 1));
            end else begin
                hit0 = 1'($urandom_range(0, 1));
                hit1 = 1'($urandom_range(0, 1));
                pmem_resp = (c == e.n_wr) || (c == e.lat - 1);
            end
            clr_stats = clr && (c == e.lat - 1);
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; clr_stats = 1'b0;
        for (int g = 0; g < gap; g++) begin
            hit0 = 1'($urandom_range(0, 1));
            hit1 = 1'($urandom_range(0, 1));
            pmem_resp = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        pmem_resp = 1'b0;
    endtask

    // Monitor: measures each transaction and checks it against the scoreboard head.
    initial begin : monitor
        int cyc, n_wr, n_rd, bad_ma;
        logic pend;
        exp_t pe;
        cyc = 0; n_wr = 0; n_rd = 0; bad_ma = 0; pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0; n_wr = 0; n_rd = 0; bad_ma = 0; pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("hit_count", 32'(hit_count), 32'(pe.c_hit));
                    chk("miss_count", 32'(miss_count), 32'(pe.c_miss));
                    chk("wb_count", 32'(wb_count), 32'(pe.c_wb));
                    pend = 1'b0;
                end
                if (mem_read || mem_write) begin
                    cyc++;
                    if (pmem_write) n_wr++;
                    if (pmem_read) n_rd++;
                    if ((pmem_write && ma_sel) || (pmem_read && !ma_sel) || (pmem_read && pmem_write))
                        bad_ma++;
                    if (mem_resp) begin
                        if (sb_q.size() == 0) begin
                            vectors++; miscompares++;
                            $display("FAIL unexpected_resp: got mem_resp expected none at %0t", $time);
                        end else begin
                            pe = sb_q.pop_front();
                            chk("latency", 32'(cyc), 32'(pe.lat));
                            chk("wb_cycles", 32'(n_wr), 32'(pe.n_wr));
                            chk("fill_cycles", 32'(n_rd), 32'(pe.n_rd));
                            chk("resp_outputs", 32'(out_vec), 32'(pe.resp));
                            chk("ma_sel_consistency", 32'(bad_ma), 32'd0);
                            pend = 1'b1;
                        end
                        cyc = 0; n_wr = 0; n_rd = 0; bad_ma = 0;
                    end
                end else begin
                    chk("idle_outputs", 32'({mem_resp, out_vec}), 32'd0);
                end
            end
        end
    end

    initial begin : driver
        logic wr, rd;
        logic [1:0] hits;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
        lru_valid = 1'b0; lru_dirty = 1'b0; pmem_resp = 1'b0; clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_counters", 32'({hit_count, miss_count, wb_count}), 32'd0);
        @(posedge clk); #1;

        // Read hits on way 1 until the hit counter must saturate.
        for (int i = 0; i < 17; i++) do_txn(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1, 1, 1'b0, i % 2);
        do_txn(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1, 1, 1'b0, 1);   // write hit way 0
        do_txn(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1, 3, 1'b0, 1);   // clean miss, 3 fill cycles
        do_txn(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2, 2, 1'b0, 1);   // dirty miss, 2 WB + 2 fill
        do_txn(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1, 1, 1'b0, 1);   // read+write: write wins
        do_txn(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1, 1, 1'b1, 1);   // clear beats hit increment

        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            hits = ($urandom_range(0, 9) < 6) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_txn(wr, rd, hits, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(1, 4), $urandom_range(1, 4), ($urandom_range(0, 11) == 0),
                   $urandom_range(0, 2));
        end

        // Reset during the second writeback cycle aborts the miss without a response.
        mem_write = 1'b1; mem_read = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
        lru_valid = 1'b1; lru_dirty = 1'b1; pmem_resp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        chk("abort_wb_active", 32'(pmem_write), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_pmem_write", 32'({pmem_write, pmem_read, mem_resp}), 32'd0);
        chk("abort_counters", 32'({hit_count, miss_count, wb_count}), 32'd0);
        m_hit = 0; m_miss = 0; m_wb = 0;
        @(posedge clk); #1;
        do_txn(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1, 2, 1'b0, 1);
        do_txn(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1, 1, 1'b0, 2);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_control.md
Name: dcache_control

Overview:
- Control FSM for the 2-way set-associative, write-back, LRU data cache.
- Sequences hit servicing, dirty-victim writeback and line fill over the physical-memory port.
- Drives every datapath mux select: way, data wdata, data wren, response, memory address, hit, dirty wren and LRU wdata.
- Maintains saturating hit, miss and writeback performance counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
mem_read  in  1  CPU read request; held until mem_resp
mem_write  in  1  CPU write request; held until mem_resp
hit0, hit1  in  1 each  tag match AND valid, way 0 / way 1
lru_valid  in  1  valid bit of the LRU way in the indexed set
lru_dirty  in  1  dirty bit of the LRU way in the indexed set
pmem_resp  in  1  physical memory transaction complete
clr_stats  in  1  synchronous clear of the counters
mem_resp  out  1  CPU response
pmem_read  out  1  line read request to physical memory
pmem_write  out  1  line write request to physical memory
way_sel  out  1  0 = wayhit, 1 = waylru
data_wdata_sel  out  2  00 = from_cpu, 01 = from_mem, 10 = mem_mask_cpu
data_wren_sel  out  1  0 = as_lru, 1 = as_hit
resp_sel  out  1  0 = waymux_out, 1 = pmem_read
ma_sel  out  1  0 = waylru address, 1 = cpu address
hit_sel  out  2  00 = as_hit, 10 = force_zero, 11 = force_one
dirty_wren_sel  out  1  0 = way_hit, 1 = way_lru
lru_wdata_sel  out  1  0 = inv_lru, 1 = inv_hit
data_we, tag_we, valid_we, dirty_we, lru_we  out  1 each  array load enables
dirty_wdata  out  1  value written to the selected dirty bit
hit_count, miss_count, wb_count  out  CNT_W each  performance counters

Behaviour:
General
- req = mem_read | mem_write; hit = hit0 | hit1.
- If both read and write are asserted, write takes priority.
- Outputs are combinational from state and inputs (Mealy). State and counters are registered.
- Any output not listed for a state/condition is 0.
- Reset: state = IDLE, all counters = 0. With no request, every output is 0.
- rst asserted mid-WB or mid-FILL: next cycle is IDLE and pmem_read/pmem_write drop. The partial line is not written, and no mem_resp is issued.

IDLE
- No req: all outputs 0; stay in IDLE.
- req & hit (single-cycle hit): hit_sel = 00, mem_resp = 1, way_sel = 0, resp_sel = 0, lru_we = 1, lru_wdata_sel = 1. Stay in IDLE.
- Hit with mem_write additionally: data_we = 1, data_wdata_sel = 00, data_wren_sel = 1, dirty_we = 1, dirty_wren_sel = 0, dirty_wdata = 1.
- req & !hit & lru_valid & lru_dirty: hit_sel = 10, go to WB.
- req & !hit otherwise: hit_sel = 10, go to FILL.

WB
- Outputs: hit_sel = 10, ma_sel = 0, way_sel = 1, pmem_write = 1.
- pmem_resp: go to FILL; else stay.

FILL
- Outputs: hit_sel = 10, ma_sel = 1, pmem_read = 1.
- On pmem_resp, same cycle:
  - Array writes: data_we = 1, data_wren_sel = 0, tag_we = 1, valid_we = 1, dirty_we = 1, dirty_wren_sel = 1.
  - Data source: data_wdata_sel = 10 if write, else 01. dirty_wdata = mem_write.
  - LRU: lru_we = 1, lru_wdata_sel = 0.
  - Response: hit_sel = 11, mem_resp = 1, resp_sel = 1. Go to IDLE.
- No pmem_resp: stay in FILL.
- pmem_resp is ignored in IDLE.

Counters
- Increment on:
  - hit_count: IDLE hit response.
  - miss_count: IDLE to WB or IDLE to FILL.
  - wb_count: WB to FILL.
- Each counter saturates at all-ones.
- clr_stats zeroes all counters; it wins over a same-cycle increment.

Miss latency
- Clean miss: 1 IDLE cycle + FILL cycles to pmem_resp.
- Dirty miss: adds WB cycles.

Test Plan:
- Reset, then mem_read with hit1 = 1 -> same cycle: mem_resp = 1, lru_we = 1, lru_wdata_sel = 1, data_we = 0; hit_count = 1 next cycle.
- mem_write with hit0 = 1 -> data_we = 1, data_wdata_sel = 00, data_wren_sel = 1, dirty_we = 1, dirty_wdata = 1, mem_resp = 1, single cycle.
- mem_read miss, lru_valid = 1, lru_dirty = 0, pmem_resp on 3rd FILL cycle -> pmem_read high 3 cycles, pmem_write never. Final cycle: mem_resp = 1, resp_sel = 1, data_wdata_sel = 01, tag_we = valid_we = 1, dirty_wdata = 0. miss_count = 1.
- mem_write miss, dirty victim, pmem_resp after 2 WB cycles then 2 FILL cycles:
  - WB: pmem_write = 1 with ma_sel = 0 for 2 cycles.
  - FILL: pmem_read = 1 with ma_sel = 1.
  - Final cycle: data_wdata_sel = 10, dirty_wdata = 1.
  - Counters: wb_count = 1, miss_count = 1.
- rst asserted in 2nd WB cycle -> next cycle pmem_write = 0, state IDLE, no mem_resp, all counters 0.
- CNT_W = 4, 17 read hits -> hit_count stays 15. clr_stats concurrent with a hit -> hit_count = 0.
